// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer for the frequency meter: produces the counter clear, gate window,
// result latch and display hold, with manual or overflow/underrange driven auto-ranging.
module freq_meter_ctrl #(
    parameter int CLK_FREQ   = 50000000,
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_CYC   = 25000000,
    parameter int CW         = 26
) (
    input  logic       CLK_50M,
    input  logic       nCLR,
    input  logic       Run,
    input  logic [1:0] Range_Sel,
    input  logic       Auto_Range,
    input  logic       Cnt_Ovf,
    input  logic       Cnt_Low,
    output logic       Gate_En,
    output logic       Clear_Pulse,
    output logic       Latch_Pulse,
    output logic [1:0] Range_Cur,
    output logic       Ovf_Flag,
    output logic       Busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH,
        HOLD
    } stateType;

    // The timer counts down to zero, so each load is the state length minus one.
    localparam logic [CW-1:0] GATE_LOAD0  = CW'(CLK_FREQ - 1);
    localparam logic [CW-1:0] GATE_LOAD1  = CW'(CLK_FREQ / 10 - 1);
    localparam logic [CW-1:0] GATE_LOAD2  = CW'(CLK_FREQ / 100 - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYC - 1);

    stateType      state, nextState;
    logic [CW-1:0] timer, nextTimer;
    logic [1:0]    nextRange;
    logic          nextOvf;
    logic          decPending, nextDec;
    logic          autoHeld, nextAuto;
    logic          gateNext, clearNext, latchNext, busyNext;

    function automatic logic [1:0] mapRange(input logic [1:0] sel);
        return (sel == 2'd3) ? 2'd2 : sel;
    endfunction

    function automatic logic [CW-1:0] gateLoad(input logic [1:0] r);
        case (r)
            2'd0:    return GATE_LOAD0;
            2'd1:    return GATE_LOAD1;
            default: return GATE_LOAD2;
        endcase
    endfunction

    // NOTE: every register uses non-blocking assignment so all of them update from the same pre-edge values.
    always_ff @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) begin
            state       <= IDLE;
            timer       <= '0;
            Range_Cur   <= 2'd0;
            Ovf_Flag    <= 1'b0;
            decPending  <= 1'b0;
            autoHeld    <= 1'b0;
            Gate_En     <= 1'b0;
            Clear_Pulse <= 1'b0;
            Latch_Pulse <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= nextState;
            timer       <= nextTimer;
            Range_Cur   <= nextRange;
            Ovf_Flag    <= nextOvf;
            decPending  <= nextDec;
            autoHeld    <= nextAuto;
            Gate_En     <= gateNext;
            Clear_Pulse <= clearNext;
            Latch_Pulse <= latchNext;
            Busy        <= busyNext;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned and infers a latch.
        nextState = state;
        nextTimer = timer;
        nextRange = Range_Cur;
        nextOvf   = Ovf_Flag;
        nextDec   = decPending;
        nextAuto  = autoHeld;

        case (state)
            IDLE: begin
                if (Run) begin
                    nextState = CLEAR;
                    nextRange = mapRange(Range_Sel);
                end
            end
            CLEAR: nextState = GATE;
            GATE: begin
                if (timer == '0) nextState = SETTLE;
            end
            SETTLE: begin
                if (timer == '0) begin
                    if (Auto_Range && Cnt_Ovf && Range_Cur != 2'd2) begin
                        nextState = CLEAR;
                        nextRange = Range_Cur + 2'd1;
                    end else begin
                        nextState = LATCH;
                        nextOvf   = Cnt_Ovf;
                        nextDec   = Auto_Range && Cnt_Low && !Cnt_Ovf;
                        nextAuto  = Auto_Range;
                    end
                end
            end
            LATCH: nextState = HOLD;
            HOLD: begin
                if (timer == '0) begin
                    if (Run) begin
                        nextState = CLEAR;
                        if (!autoHeld) begin
                            nextRange = mapRange(Range_Sel);
                        end else if (decPending && Range_Cur != 2'd0) begin
                            nextRange = Range_Cur - 2'd1;
                        end
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase

        // Reload on every state entry; the gate length follows the range that is entering CLEAR/GATE.
        if (nextState != state) begin
            case (nextState)
                GATE:    nextTimer = gateLoad(nextRange);
                SETTLE:  nextTimer = SETTLE_LOAD;
                HOLD:    nextTimer = HOLD_LOAD;
                default: nextTimer = '0;
            endcase
        end else if (timer != '0) begin
            nextTimer = timer - 1'b1;
        end
    end

    always_comb begin
        gateNext  = (nextState == GATE);
        clearNext = (nextState == CLEAR);
        latchNext = (nextState == LATCH);
        busyNext  = (nextState != IDLE);
    end

endmodule
